// File: rtl/fcw_sweep_ctrl.sv
// Linear tuning-word sweep sequencer feeding the sine_dds fcw input.
// Optional SWEEP_PINGPONG_EN: bounce between start and stop until aborted.
module fcw_sweep_ctrl #(
    parameter int FCW_W   = 24,
    parameter int DWELL_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    input  logic [FCW_W-1:0]   fcw_start,
    input  logic [FCW_W-1:0]   fcw_stop,
    input  logic [FCW_W-1:0]   fcw_step,
    input  logic [DWELL_W-1:0] dwell,
    output logic [FCW_W-1:0]   fcw,
    output logic               busy,
    output logic               step_pulse,
    output logic               done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DWELL = 2'd1,
        S_FINAL = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [FCW_W-1:0]   fcw_q, fcw_d;
    logic [FCW_W-1:0]   stop_q, stop_d;
    logic [FCW_W-1:0]   step_q, step_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic               dir_q, dir_d;
    logic               degen_q, degen_d;
    logic               busy_q, busy_d;
    logic               step_pulse_q, step_pulse_d;
    logic               done_q, done_d;
`ifdef SWEEP_PINGPONG_EN
    logic [FCW_W-1:0]   start_q, start_d;
`endif

    logic               eff_down;
    logic [FCW_W-1:0]   eff_stop;
    logic [FCW_W:0]     next_wide;
    logic               reach;
    logic               cnt_zero;
    logic               degen_in;

    assign cnt_zero = (cnt_q == '0);
    assign degen_in = (fcw_step == '0) || (fcw_start == fcw_stop);

    // Next candidate word; the extra bit carries the overflow/borrow so the
    // sweep clamps at stop instead of wrapping around the tuning range.
    always_comb begin
        eff_down = dir_q;
        eff_stop = stop_q;
`ifdef SWEEP_PINGPONG_EN
        if (state_q == S_FINAL) begin
            eff_down = ~dir_q;
            eff_stop = start_q;
        end
`endif
        if (eff_down) begin
            next_wide = {1'b0, fcw_q} - {1'b0, step_q};
            reach     = next_wide[FCW_W] || (next_wide[FCW_W-1:0] <= eff_stop);
        end else begin
            next_wide = {1'b0, fcw_q} + {1'b0, step_q};
            reach     = next_wide[FCW_W] || (next_wide[FCW_W-1:0] >= eff_stop);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_d = degen_in ? S_FINAL : S_DWELL;
                    end
                end
                S_DWELL: begin
                    if (cnt_zero && reach) begin
                        state_d = S_FINAL;
                    end
                end
                S_FINAL: begin
                    if (cnt_zero) begin
`ifdef SWEEP_PINGPONG_EN
                        state_d = (!degen_q && !reach) ? S_DWELL : S_FINAL;
`else
                        state_d = S_IDLE;
`endif
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        fcw_d        = fcw_q;
        stop_d       = stop_q;
        step_d       = step_q;
        dwell_d      = dwell_q;
        cnt_d        = cnt_q;
        dir_d        = dir_q;
        degen_d      = degen_q;
        busy_d       = busy_q;
        step_pulse_d = 1'b0;
        done_d       = 1'b0;
`ifdef SWEEP_PINGPONG_EN
        start_d      = start_q;
`endif
        if (abort) begin
            fcw_d  = '0;
            busy_d = 1'b0;
            cnt_d  = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        stop_d  = fcw_stop;
                        step_d  = fcw_step;
                        dwell_d = dwell;
                        fcw_d   = fcw_start;
                        cnt_d   = dwell;
                        busy_d  = 1'b1;
                        dir_d   = (fcw_stop < fcw_start);
                        degen_d = degen_in;
`ifdef SWEEP_PINGPONG_EN
                        start_d = fcw_start;
`endif
                    end
                end
                S_DWELL: begin
                    if (!cnt_zero) begin
                        cnt_d = cnt_q - DWELL_W'(1);
                    end else begin
                        fcw_d        = reach ? stop_q : next_wide[FCW_W-1:0];
                        step_pulse_d = 1'b1;
                        cnt_d        = dwell_q;
                    end
                end
                S_FINAL: begin
                    if (!cnt_zero) begin
                        cnt_d = cnt_q - DWELL_W'(1);
                    end else begin
`ifdef SWEEP_PINGPONG_EN
                        cnt_d = dwell_q;
                        if (!degen_q) begin
                            start_d      = stop_q;
                            stop_d       = start_q;
                            dir_d        = ~dir_q;
                            fcw_d        = reach ? start_q : next_wide[FCW_W-1:0];
                            step_pulse_d = 1'b1;
                        end
`else
                        done_d = 1'b1;
                        busy_d = 1'b0;
`endif
                    end
                end
                default: begin
                    busy_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fcw_q        <= '0;
            stop_q       <= '0;
            step_q       <= '0;
            dwell_q      <= '0;
            cnt_q        <= '0;
            dir_q        <= 1'b0;
            degen_q      <= 1'b0;
            busy_q       <= 1'b0;
            step_pulse_q <= 1'b0;
            done_q       <= 1'b0;
`ifdef SWEEP_PINGPONG_EN
            start_q      <= '0;
`endif
        end else begin
            fcw_q        <= fcw_d;
            stop_q       <= stop_d;
            step_q       <= step_d;
            dwell_q      <= dwell_d;
            cnt_q        <= cnt_d;
            dir_q        <= dir_d;
            degen_q      <= degen_d;
            busy_q       <= busy_d;
            step_pulse_q <= step_pulse_d;
            done_q       <= done_d;
`ifdef SWEEP_PINGPONG_EN
            start_q      <= start_d;
`endif
        end
    end

    assign fcw        = fcw_q;
    assign busy       = busy_q;
    assign step_pulse = step_pulse_q;
    assign done       = done_q;

endmodule

// File: tb/tb_fcw_sweep_ctrl.sv
// Randomized self-checking bench for fcw_sweep_ctrl against a list-based sweep model.
module tb_fcw_sweep_ctrl;

    logic        clk;
    logic        reset;
    logic        start;
    logic        abort;
    logic [23:0] fcw_start;
    logic [23:0] fcw_stop;
    logic [23:0] fcw_step;
    logic [15:0] dwell;
    logic [23:0] fcw;
    logic        busy;
    logic        step_pulse;
    logic        done;

    int checks = 0;
    int errors = 0;

    logic [23:0] exp_q[$];

    fcw_sweep_ctrl #(.FCW_W(24), .DWELL_W(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .abort      (abort),
        .fcw_start  (fcw_start),
        .fcw_stop   (fcw_stop),
        .fcw_step   (fcw_step),
        .dwell      (dwell),
        .fcw        (fcw),
        .busy       (busy),
        .step_pulse (step_pulse),
        .done       (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: list of distinct tuning words visited from s toward e.
    function automatic void build_leg(input longint s, input longint e, input longint st);
        longint v;
        exp_q.push_back(24'(s));
        if (st == 0 || s == e) return;
        v = s;
        while (1) begin
            if (e > s) v = v + st;
            else       v = v - st;
            if ((e > s && v >= e) || (e < s && v <= e)) begin
                exp_q.push_back(24'(e));
                break;
            end
            exp_q.push_back(24'(v));
        end
    endfunction

    task automatic run_sweep(input logic [23:0] s, input logic [23:0] e, input logic [23:0] st,
                             input logic [15:0] d, input bit poke, input string name);
        int hold;
        int n;
        logic [23:0] ef;
        logic        esp;
        exp_q.delete();
        build_leg(longint'(s), longint'(e), longint'(st));
        hold = int'(d) + 1;
        n = exp_q.size() * hold;
        fcw_start = s; fcw_stop = e; fcw_step = st; dwell = d;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < n; i++) begin
            ef  = exp_q[i / hold];
            esp = (i > 0) && (i % hold == 0);
            checks++;
            if (fcw !== ef) begin errors++; $display("FAIL %s fcw cyc %0d: got %h want %h", name, i, fcw, ef); end
            checks++;
            if (busy !== 1'b1) begin errors++; $display("FAIL %s busy cyc %0d: got %b want 1", name, i, busy); end
            checks++;
            if (step_pulse !== esp) begin errors++; $display("FAIL %s step_pulse cyc %0d: got %b want %b", name, i, step_pulse, esp); end
            checks++;
            if (done !== 1'b0) begin errors++; $display("FAIL %s early done cyc %0d: got %b want 0", name, i, done); end
            fcw_start = 24'($urandom); fcw_stop = 24'($urandom);
            fcw_step  = 24'($urandom); dwell = 16'($urandom);
            start = poke && ($urandom_range(0, 3) == 0);
            tick();
        end
        start = 1'b0;
        ef = exp_q[exp_q.size() - 1];
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL %s busy end: got %b want 0", name, busy); end
        checks++;
        if (done !== 1'b1) begin errors++; $display("FAIL %s done pulse: got %b want 1", name, done); end
        checks++;
        if (fcw !== ef) begin errors++; $display("FAIL %s fcw end: got %h want %h", name, fcw, ef); end
        checks++;
        if (step_pulse !== 1'b0) begin errors++; $display("FAIL %s step_pulse end: got %b want 0", name, step_pulse); end
        tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL %s after done: done %b busy %b want 0 0", name, done, busy); end
        checks++;
        if (fcw !== ef) begin errors++; $display("FAIL %s idle hold: got %h want %h", name, fcw, ef); end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b1; abort = 1'b0;
        fcw_start = 24'h123456; fcw_stop = 24'h654321; fcw_step = 24'h000100; dwell = 16'd2;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (fcw !== 24'h0 || busy !== 1'b0 || done !== 1'b0 || step_pulse !== 1'b0) begin
                errors++;
                $display("FAIL reset hold: fcw %h busy %b done %b sp %b want 0 0 0 0", fcw, busy, done, step_pulse);
            end
        end
        reset = 1'b0; start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (fcw !== 24'h0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL reset idle: fcw %h busy %b want 0 0", fcw, busy);
            end
        end
    endtask

    task automatic test_directed();
        run_sweep(24'h010000, 24'h040000, 24'h010000, 16'd3, 1'b1, "up_sweep");
        run_sweep(24'h000100, 24'h000250, 24'h000100, 16'd0, 1'b0, "clamp");
        run_sweep(24'h400000, 24'h100000, 24'h100000, 16'd1, 1'b0, "down_sweep");
        run_sweep(24'hFFF000, 24'hFFFFFF, 24'h800000, 16'd2, 1'b0, "carry_guard");
        run_sweep(24'h000800, 24'h000000, 24'h001000, 16'd1, 1'b0, "borrow_guard");
        run_sweep(24'h222222, 24'h222222, 24'h000010, 16'd2, 1'b0, "degen_equal");
        run_sweep(24'h100000, 24'h200000, 24'h000000, 16'd3, 1'b0, "degen_step0");
    endtask

    task automatic test_random();
        logic [23:0] s, e, st;
        logic [15:0] d;
        int diff;
        int k;
        for (int r = 0; r < 12; r++) begin
            s = 24'($urandom);
            e = 24'($urandom);
            diff = (e > s) ? int'(e - s) : int'(s - e);
            st = 24'($urandom_range(32'hFFFFFF, diff / 12 + 1));
            k = $urandom_range(0, 7);
            if (k == 0) st = 24'h0;
            if (k == 1) e = s;
            d = 16'($urandom_range(0, 4));
            run_sweep(s, e, st, d, 1'b1, "random");
        end
    endtask

    task automatic test_abort_mid();
        fcw_start = 24'h010000; fcw_stop = 24'h040000; fcw_step = 24'h010000; dwell = 16'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (fcw !== 24'h010000) begin errors++; $display("FAIL abort_pre fcw: got %h want 010000", fcw); end
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++;
        if (fcw !== 24'h0) begin errors++; $display("FAIL abort fcw: got %h want 0", fcw); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL abort busy: got %b want 0", busy); end
        for (int i = 0; i < 20; i++) begin
            checks++;
            if (done !== 1'b0 || step_pulse !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL abort quiet cyc %0d: done %b sp %b busy %b want 0 0 0", i, done, step_pulse, busy);
            end
            tick();
        end
    endtask

    task automatic test_start_abort_idle();
        run_sweep(24'h000010, 24'h000030, 24'h000010, 16'd0, 1'b0, "pre_idle");
        fcw_start = 24'h500000; fcw_stop = 24'h600000; fcw_step = 24'h010000; dwell = 16'd0;
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (busy !== 1'b0 || fcw !== 24'h0) begin
                errors++;
                $display("FAIL start_abort_idle cyc %0d: busy %b fcw %h want 0 000000", i, busy, fcw);
            end
            tick();
        end
    endtask

    task automatic test_async_reset();
        fcw_start = 24'h300000; fcw_stop = 24'h700000; fcw_step = 24'h100000; dwell = 16'd2;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        #2 reset = 1'b1;
        #1;
        checks++;
        if (fcw !== 24'h0 || busy !== 1'b0 || step_pulse !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: fcw %h busy %b sp %b done %b want 0 0 0 0", fcw, busy, step_pulse, done);
        end
        tick();
        reset = 1'b0;
        tick();
        tick();
        checks++;
        if (busy !== 1'b0 || fcw !== 24'h0) begin
            errors++;
            $display("FAIL async_reset after: busy %b fcw %h want 0 000000", busy, fcw);
        end
    endtask

`ifdef SWEEP_PINGPONG_EN
    task automatic test_pingpong();
        int mark;
        logic esp;
        exp_q.delete();
        build_leg(longint'(24'h010000), longint'(24'h040000), longint'(24'h010000));
        for (int l = 0; l < 4; l++) begin
            mark = exp_q.size();
            if (l % 2 == 0) build_leg(longint'(24'h040000), longint'(24'h010000), longint'(24'h010000));
            else            build_leg(longint'(24'h010000), longint'(24'h040000), longint'(24'h010000));
            exp_q.delete(mark);
        end
        fcw_start = 24'h010000; fcw_stop = 24'h040000; fcw_step = 24'h010000; dwell = 16'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < exp_q.size(); i++) begin
            esp = (i > 0);
            checks++;
            if (fcw !== exp_q[i]) begin errors++; $display("FAIL pingpong fcw cyc %0d: got %h want %h", i, fcw, exp_q[i]); end
            checks++;
            if (busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL pingpong busy/done cyc %0d: %b %b want 1 0", i, busy, done); end
            checks++;
            if (step_pulse !== esp) begin errors++; $display("FAIL pingpong step_pulse cyc %0d: got %b want %b", i, step_pulse, esp); end
            tick();
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || fcw !== 24'h0 || done !== 1'b0) begin
            errors++;
            $display("FAIL pingpong abort: busy %b fcw %h done %b want 0 000000 0", busy, fcw, done);
        end
    endtask
`endif

    initial begin
        reset = 1'b1; start = 1'b0; abort = 1'b0;
        fcw_start = '0; fcw_stop = '0; fcw_step = '0; dwell = '0;
        test_reset();
`ifdef SWEEP_PINGPONG_EN
        test_pingpong();
`else
        test_directed();
        test_random();
        test_start_abort_idle();
`endif
        test_abort_mid();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fcw_sweep_ctrl.md
Name: fcw_sweep_ctrl

Overview:
Frequency-sweep sequencer that sits directly upstream of sine_dds and drives its 24-bit fcw input. On a start strobe it latches a start, stop and step tuning word and a dwell count. It then steps fcw linearly from start to stop, holding each value for a programmable number of clocks. It is used for chirp and frequency-response sweeps of the sine generator without a processor in the loop.

Parameters:
FCW_W, 24, width of all tuning words (matches the sine_dds fcw width)
DWELL_W, 16, width of the dwell counter

Ports:
clk  input  1  system clock (500 MHz domain, shared with sine_dds)
reset  input  1  asynchronous, active-high reset
start  input  1  one-cycle request to begin a sweep; sampled only in IDLE
abort  input  1  synchronous sweep cancel; priority over start
fcw_start  input  FCW_W  first tuning word
fcw_stop  input  FCW_W  final tuning word
fcw_step  input  FCW_W  unsigned increment magnitude
dwell  input  DWELL_W  hold time per tuning word; D gives D+1 cycles
fcw  output  FCW_W  registered tuning word to sine_dds
busy  output  1  high while a sweep is in progress
step_pulse  output  1  one-cycle pulse on every fcw change after the first
done  output  1  one-cycle pulse when a one-shot sweep completes

Behaviour:
- Reset (async): state=IDLE; fcw=0; busy=0; step_pulse=0; done=0; internal count=0.
- States: IDLE, DWELL, FINAL.
- IDLE, start=1, abort=0, same edge:
  - latch fcw_stop, fcw_step and dwell into shadow registers.
  - set fcw<=fcw_start, cnt<=dwell, busy<=1.
  - latch dir=down if fcw_stop<fcw_start, else up.
  - go to DWELL. fcw_start is therefore visible on the cycle after start.
- Latched values: inputs are never re-read during a sweep. Changing them mid-sweep has no effect.
- DWELL, cnt!=0: cnt<=cnt-1.
- DWELL, cnt==0: compute next = fcw ± step in FCW_W+1 bits (carry/borrow kept).
  - If next passes or equals stop, or carry/borrow is set: fcw<=stop, step_pulse<=1, cnt<=dwell, go to FINAL.
  - Otherwise: fcw<=next, step_pulse<=1, cnt<=dwell, stay in DWELL.
- Degenerate cases, handled without entering DWELL stepping (dwell once at fcw_start, then FINAL-completion, no step_pulse):
  - fcw_step==0.
  - fcw_start==fcw_stop.
- FINAL, cnt!=0: decrement cnt.
- FINAL, cnt==0: done<=1 for one cycle; busy<=0; go to IDLE. fcw holds stop.
- IDLE output: fcw holds its last value.
- step_pulse and done are cleared on every cycle they are not explicitly set.
- abort=1 in any state, sampled at the clock edge:
  - state<=IDLE, fcw<=0, busy<=0, step_pulse<=0.
  - done is not asserted.
  - abort and start together in IDLE: abort wins and no sweep starts.
- start while busy: ignored, no queuing.
- Reset asserted mid-sweep: all outputs go to their reset values immediately (asynchronous); any partial sweep is discarded.

Optional Feature:
Macro SWEEP_PINGPONG_EN.
- Defined: FINAL does not end the sweep. When the final dwell expires:
  - start and stop swap, dir inverts, and the sweep continues back toward the original start.
  - This repeats indefinitely; busy stays 1 and done never pulses.
  - step_pulse fires on each turnaround.
  - Only abort or reset ends the sweep.
- Undefined: one-shot behaviour exactly as above. The logic is compiled out.

Test Plan:
- Reset: hold reset 2 cycles with start=1 -> fcw=0x000000, busy=0, done=0, step_pulse=0 throughout; no sweep after release until a new start.
- Up sweep: start=0x010000, stop=0x040000, step=0x010000, dwell=3 ->
  - fcw goes 0x010000, 0x020000, 0x030000, 0x040000, 4 cycles each.
  - busy high exactly 16 cycles; 3 step_pulses.
  - done pulses on the cycle busy falls; fcw holds 0x040000.
- Clamp, dwell=0: start=0x000100, stop=0x000250, step=0x000100 -> fcw goes 0x000100, 0x000200, 0x000250, 1 cycle each; done after 3 cycles.
- Down sweep with overflow guard:
  - start=0x400000, stop=0x100000, step=0x100000, dwell=1 -> 0x400000, 0x300000, 0x200000, 0x100000, 2 cycles each.
  - start=0xFFF000, stop=0xFFFFFF, step=0x800000 -> 0xFFF000, then 0xFFFFFF; no wrap to a low value.
- Abort/ignore:
  - Pulse start again during the up sweep -> no effect.
  - abort in the 2nd dwell cycle -> next cycle fcw=0, busy=0, no done.
  - start+abort together in IDLE -> stays idle.
- With SWEEP_PINGPONG_EN defined: up-sweep stimulus with dwell=0 -> fcw goes 0x010000, 0x020000, 0x030000, 0x040000, 0x030000, 0x020000, 0x010000, 0x020000, and so on; done never asserts; busy stays 1 until abort.
